store_rmw_unit: RTL and testbench

- Parametrised successor to the combinational store-merge mux.
- Performs sub-word stores (double/word/half/byte) at any aligned byte offset as a sequenced read-modify-write against a single-port data memory.
- Full-width stores bypass the read. Misaligned requests are rejected without touching memory.
- Sits between the store stage of the datapath and the data memory port, with a valid/ready request handshake and a one-cycle done pulse.

---
 rtl/store_pkg.sv | 28 ++
 rtl/byte_lane_merge.sv | 28 ++
 rtl/store_rmw_unit.sv | 136 +++++++++++++
 tb/tb_store_rmw_unit.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_pkg.sv
// Shared types for the store read-modify-write unit: store size codes, sequencer states
// and the helper that turns a size code into a byte count.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package store_pkg;

  // Store size as encoded on req_size: each step halves the access width.
  typedef enum logic [1:0] {
    SZ_D = 2'd0,
    SZ_W = 2'd1,
    SZ_H = 2'd2,
    SZ_B = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } state_e;

  // Bytes touched by a store of the given size: 8, 4, 2 or 1.
  function automatic logic [3:0] size_bytes(input size_e size);
    return 4'd8 >> size;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Byte-lane merge: overlays nbytes of low-aligned store data onto an old word at byte offset off.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: old_i (word read from memory), wdata_i (store data, byte 0 in lane 0),
//        off_i (byte offset of the store), nbytes_i (store width in bytes), merged_o (result).
module byte_lane_merge #(
  parameter  int DATA_W = 64,
  localparam int NB     = DATA_W / 8,
  localparam int OFFW   = $clog2(NB)
) (
  input  logic [DATA_W-1:0] old_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [OFFW-1:0]   off_i,
  input  logic [3:0]        nbytes_i,
  output logic [DATA_W-1:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < NB; i++) begin
      // Lane i lies inside the store window: take store byte (i - off).
      if ((i >= int'(off_i)) && (i < int'(off_i) + int'(nbytes_i))) begin
        merged_o[8*i +: 8] = wdata_i[8*(i - int'(off_i)) +: 8];
      end
    end
  end

endmodule

// File: rtl/store_rmw_unit.sv
// Store sequencer: applies double/word/half/byte stores to a single-port memory via read-modify-write.
// Latency: misaligned done at T+1, full-width done at T+2, sub-word done at T+3+MEM_LAT.
// Backpressure: req_ready only while IDLE; one request in flight, one idle cycle between requests.
// Ports: clk/reset (sync, active-high); req_valid/req_ready/req_addr/req_size/req_wdata (store request);
//        mem_addr/mem_rd/mem_wr/mem_wdata/mem_rdata (memory port); done/misaligned (completion status).
module store_rmw_unit
  import store_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              done,
  output logic              misaligned
);

  localparam int NB    = DATA_W / 8;
  localparam int OFFW  = $clog2(NB);
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  state_e            state_q;
  logic [OFFW-1:0]   off_q;
  logic [3:0]        nbytes_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [ADDR_W-1:0] word_addr_d;
  logic [OFFW-1:0]   off_d;
  logic [3:0]        nbytes_d;
  logic [OFFW-1:0]   size_mask_d;
  logic              misaligned_d;
  logic              full_d;
  logic [DATA_W-1:0] merged_d;

  assign word_addr_d  = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
  assign off_d        = req_addr[OFFW-1:0];
  assign nbytes_d     = size_bytes(size_e'(req_size));
  // Sizes are powers of two, so "off mod nbytes" is just the low bits under nbytes-1.
  assign size_mask_d  = OFFW'(nbytes_d - 4'd1);
  assign misaligned_d = |(off_d & size_mask_d);
  assign full_d       = ({28'd0, nbytes_d} == 32'(NB));

  // Merge reads mem_rdata directly; the result is registered into mem_wdata on the
  // edge that ends the last WAIT cycle, which is the read-data capture point.
  byte_lane_merge #(.DATA_W(DATA_W)) u_merge (
    .old_i    (mem_rdata),
    .wdata_i  (wdata_q),
    .off_i    (off_q),
    .nbytes_i (nbytes_q),
    .merged_o (merged_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      req_ready  <= 1'b1;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      off_q      <= '0;
      nbytes_q   <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            mem_addr  <= word_addr_d;
            off_q     <= off_d;
            nbytes_q  <= nbytes_d;
            wdata_q   <= req_wdata;
            if (misaligned_d) begin
              // Rejected without any memory traffic.
              state_q    <= DONE;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else if (full_d) begin
              // Whole word replaced: nothing to preserve, skip the read.
              state_q   <= WRITE;
              mem_wr    <= 1'b1;
              mem_wdata <= req_wdata;
            end else begin
              state_q <= READ;
              mem_rd  <= 1'b1;
            end
          end
        end
        READ: begin
          mem_rd  <= 1'b0;
          cnt_q   <= CNT_W'(MEM_LAT - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            mem_wdata <= merged_d;
            mem_wr    <= 1'b1;
            state_q   <= WRITE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WRITE: begin
          mem_wr  <= 1'b0;
          done    <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done       <= 1'b0;
          misaligned <= 1'b0;
          req_ready  <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_rmw_unit.sv
// Bench for store_rmw_unit: two instances (MEM_LAT=1 and MEM_LAT=3) driven by directed and
// random stores, checked against a byte-level memory/store model and cycle expectations.
// Cycle k of an observation is counted from the acceptance cycle T (k=1 is T+1).
module tb_store_rmw_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_wdata;

  logic        rv    [2];
  logic        rr    [2];
  logic        mrd   [2];
  logic        mwr   [2];
  logic        dn    [2];
  logic        mis   [2];
  logic [63:0] maddr [2];
  logic [63:0] mwd   [2];
  logic [63:0] mrdat [2];
  logic [63:0] old_word [2];

  int n_tests = 0;
  int n_fail  = 0;

  store_rmw_unit #(.DATA_W(64), .ADDR_W(64), .MEM_LAT(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .req_valid(rv[0]), .req_ready(rr[0]), .req_addr(req_addr), .req_size(req_size),
    .req_wdata(req_wdata), .mem_addr(maddr[0]), .mem_rd(mrd[0]), .mem_wr(mwr[0]),
    .mem_wdata(mwd[0]), .mem_rdata(mrdat[0]), .done(dn[0]), .misaligned(mis[0])
  );

  store_rmw_unit #(.DATA_W(64), .ADDR_W(64), .MEM_LAT(3)) dut_l3 (
    .clk(clk), .reset(reset),
    .req_valid(rv[1]), .req_ready(rr[1]), .req_addr(req_addr), .req_size(req_size),
    .req_wdata(req_wdata), .mem_addr(maddr[1]), .mem_rd(mrd[1]), .mem_wr(mwr[1]),
    .mem_wdata(mwd[1]), .mem_rdata(mrdat[1]), .done(dn[1]), .misaligned(mis[1])
  );

  function automatic int lat_of(input int j);
    return (j == 0) ? 1 : 3;
  endfunction

  // Memory read side: garbage until MEM_LAT cycles after mem_rd, then the stored word.
  bit rpend [2];
  int rcnt  [2];
  always @(posedge clk) begin
    for (int j = 0; j < 2; j++) begin
      if (reset) begin
        rpend[j] = 1'b0;
      end else begin
        if (mrd[j]) begin
          rpend[j] = 1'b1;
          rcnt[j]  = lat_of(j) - 1;
        end else if (rpend[j] && rcnt[j] > 0) begin
          rcnt[j] = rcnt[j] - 1;
        end
        if (rpend[j] && rcnt[j] == 0) begin
          mrdat[j] <= old_word[j];
          rpend[j] = 1'b0;
        end else if (rpend[j]) begin
          mrdat[j] <= {$urandom, $urandom};
        end
      end
    end
  end

  typedef struct packed {
    logic        rdy0;
    logic [63:0] addr1;
    int          rd_n;
    int          rd_cyc;
    logic [63:0] rd_addr;
    int          wr_n;
    int          wr_cyc;
    logic [63:0] wr_addr;
    logic [63:0] wr_data;
    int          done_cyc;
    logic        mis;
    logic        rdy_after;
    logic        bad;
  } obs_t;

  // Issue one store on instance j and record what the memory port and status outputs do.
  // Request inputs are scrambled right after acceptance; the unit must ignore them.
  task automatic do_req(input int j, input logic [63:0] a, input logic [1:0] s,
                        input logic [63:0] w, output obs_t o);
    bit fin;
    o = '0;
    o.rd_cyc = -1;
    o.wr_cyc = -1;
    o.done_cyc = -1;
    fin = 1'b0;
    @(negedge clk);
    req_addr = a; req_size = s; req_wdata = w; rv[j] = 1'b1;
    o.rdy0 = rr[j];
    for (int k = 1; k <= 30 && !fin; k++) begin
      @(negedge clk);
      if (k == 1) begin
        rv[j] = 1'b0;
        req_addr = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        req_size = 2'($urandom);
        o.addr1 = maddr[j];
      end
      if (mrd[j]) begin o.rd_n++; o.rd_cyc = k; o.rd_addr = maddr[j]; end
      if (mwr[j]) begin o.wr_n++; o.wr_cyc = k; o.wr_addr = maddr[j]; o.wr_data = mwd[j]; end
      if ((mrd[j] && mwr[j]) || (mis[j] && !dn[j])) o.bad = 1'b1;
      if (o.done_cyc < 0 && maddr[j] !== o.addr1) o.bad = 1'b1;
      if (o.done_cyc >= 0) begin
        o.rdy_after = rr[j];
        fin = 1'b1;
      end else if (dn[j]) begin
        o.done_cyc = k;
        o.mis = mis[j];
      end
    end
  endtask

  // Reference: write bytes 0..n-1 of the store data into bytes off..off+n-1 of the old word.
  function automatic logic [63:0] ref_merge(input logic [63:0] old, input logic [63:0] a,
                                            input logic [1:0] s, input logic [63:0] w);
    logic [63:0] r;
    int n, off;
    r = old;
    n = 8 >> s;
    off = int'(a % 64'd8);
    for (int b = 0; b < n; b++) r[8*(off + b) +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic obs_t expect_obs(input int lat, input logic [63:0] a, input logic [1:0] s,
                                      input logic [63:0] w, input logic [63:0] old);
    obs_t e;
    int n;
    logic [63:0] word;
    e = '0;
    n = 8 >> s;
    word = a - (a % 64'd8);
    e.rdy0 = 1'b1;
    e.addr1 = word;
    e.rd_cyc = -1;
    e.wr_cyc = -1;
    e.rdy_after = 1'b1;
    if ((a % 64'd8) % 64'(n) != 0) begin
      e.done_cyc = 1;
      e.mis = 1'b1;
    end else if (n == 8) begin
      e.wr_n = 1; e.wr_cyc = 1; e.wr_addr = word; e.wr_data = w;
      e.done_cyc = 2;
    end else begin
      e.rd_n = 1; e.rd_cyc = 1; e.rd_addr = word;
      e.wr_n = 1; e.wr_cyc = 2 + lat; e.wr_addr = word; e.wr_data = ref_merge(old, a, s, w);
      e.done_cyc = 3 + lat;
    end
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      n_tests++;
      if ({rr[j], mrd[j], mwr[j], dn[j], mis[j]} !== 5'b10000 || maddr[j] !== 64'd0 || mwd[j] !== 64'd0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: rdy/rd/wr/done/mis=%b%b%b%b%b addr=%h wdata=%h, need 10000 addr=0 wdata=0",
                 j, rr[j], mrd[j], mwr[j], dn[j], mis[j], maddr[j], mwd[j]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_byte_store();
    obs_t o;
    old_word[0] = 64'h1122334455667788;
    do_req(0, 64'h1003, 2'd3, 64'hAB, o);
    n_tests++;
    if (o.rd_cyc !== 1 || o.rd_addr !== 64'h1000 || o.rd_n !== 1) begin
      n_fail++; $display("FAIL byte_read: cyc=%0d addr=%h n=%0d, need cyc=1 addr=1000 n=1", o.rd_cyc, o.rd_addr, o.rd_n);
    end
    n_tests++;
    if (o.wr_cyc !== 3 || o.wr_data !== 64'h11223344AB667788 || o.wr_addr !== 64'h1000) begin
      n_fail++; $display("FAIL byte_write: cyc=%0d data=%h addr=%h, need cyc=3 data=11223344ab667788 addr=1000", o.wr_cyc, o.wr_data, o.wr_addr);
    end
    n_tests++;
    if (o.done_cyc !== 4 || o.mis !== 1'b0 || o.rdy_after !== 1'b1) begin
      n_fail++; $display("FAIL byte_done: done=%0d mis=%b rdy_next=%b, need done=4 mis=0 rdy_next=1", o.done_cyc, o.mis, o.rdy_after);
    end
  endtask

  task automatic test_word_store();
    obs_t o;
    old_word[0] = 64'h0123456789ABCDEF;
    do_req(0, 64'h2004, 2'd1, 64'hDEADBEEF, o);
    n_tests++;
    if (o.wr_data !== 64'hDEADBEEF89ABCDEF || o.wr_addr !== 64'h2000 || o.wr_cyc !== 3) begin
      n_fail++; $display("FAIL word_write: data=%h addr=%h cyc=%0d, need deadbeef89abcdef at 2000 cyc=3", o.wr_data, o.wr_addr, o.wr_cyc);
    end
  endtask

  task automatic test_double_store();
    obs_t o;
    old_word[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_req(0, 64'h3000, 2'd0, 64'hCAFEF00D12345678, o);
    n_tests++;
    if (o.rd_n !== 0) begin
      n_fail++; $display("FAIL double_no_read: reads=%0d, need 0", o.rd_n);
    end
    n_tests++;
    if (o.wr_cyc !== 1 || o.wr_data !== 64'hCAFEF00D12345678 || o.wr_addr !== 64'h3000) begin
      n_fail++; $display("FAIL double_write: cyc=%0d data=%h addr=%h, need cyc=1 cafef00d12345678 at 3000", o.wr_cyc, o.wr_data, o.wr_addr);
    end
    n_tests++;
    if (o.done_cyc !== 2) begin
      n_fail++; $display("FAIL double_done: done=%0d, need 2", o.done_cyc);
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    do_req(0, 64'h4003, 2'd2, 64'h1234, o);
    n_tests++;
    if (o.done_cyc !== 1 || o.mis !== 1'b1) begin
      n_fail++; $display("FAIL misaligned_done: done=%0d mis=%b, need done=1 mis=1", o.done_cyc, o.mis);
    end
    n_tests++;
    if (o.rd_n !== 0 || o.wr_n !== 0 || o.bad !== 1'b0) begin
      n_fail++; $display("FAIL misaligned_quiet: reads=%0d writes=%0d bad=%b, need 0 0 0", o.rd_n, o.wr_n, o.bad);
    end
  endtask

  task automatic test_reset_mid_op();
    int wr_seen;
    old_word[0] = 64'h5555_AAAA_5555_AAAA;
    @(negedge clk);
    req_addr = 64'h1005; req_size = 2'd3; req_wdata = 64'h77; rv[0] = 1'b1;
    @(negedge clk);
    rv[0] = 1'b0;
    n_tests++;
    if (mrd[0] !== 1'b1) begin
      n_fail++; $display("FAIL midreset_read: mem_rd=%b, need 1", mrd[0]);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({rr[0], mrd[0], mwr[0], dn[0]} !== 4'b1000) begin
      n_fail++; $display("FAIL midreset_idle: rdy/rd/wr/done=%b%b%b%b, need 1000", rr[0], mrd[0], mwr[0], dn[0]);
    end
    reset = 1'b0;
    wr_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (mwr[0] || dn[0]) wr_seen++;
    end
    n_tests++;
    if (wr_seen !== 0) begin
      n_fail++; $display("FAIL midreset_no_write: write/done cycles=%0d, need 0", wr_seen);
    end
  endtask

  task automatic test_lat3_half();
    obs_t o;
    old_word[1] = 64'd0;
    do_req(1, 64'h5006, 2'd2, 64'hBEEF, o);
    n_tests++;
    if (o.rd_cyc !== 1 || o.wr_cyc !== 5 || o.done_cyc !== 6) begin
      n_fail++; $display("FAIL lat3_timing: rd=%0d wr=%0d done=%0d, need 1 5 6", o.rd_cyc, o.wr_cyc, o.done_cyc);
    end
    n_tests++;
    if (o.wr_data !== 64'hBEEF000000000000 || o.wr_addr !== 64'h5000) begin
      n_fail++; $display("FAIL lat3_write: data=%h addr=%h, need beef000000000000 at 5000", o.wr_data, o.wr_addr);
    end
  endtask

  task automatic test_back_to_back();
    int wcyc [$];
    logic [63:0] wdat [$];
    logic rdy_k2, rdy_k3;
    @(negedge clk);
    req_addr = 64'h6000; req_size = 2'd0; req_wdata = 64'hA1A2A3A4A5A6A7A8; rv[1] = 1'b1;
    rdy_k2 = 1'b0; rdy_k3 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) req_wdata = 64'hB1B2B3B4B5B6B7B8;
      if (k == 5) rv[1] = 1'b0;
      if (k == 2) rdy_k2 = rr[1];
      if (k == 3) rdy_k3 = rr[1];
      if (mwr[1]) begin wcyc.push_back(k); wdat.push_back(mwd[1]); end
    end
    n_tests++;
    if (rdy_k2 !== 1'b0 || rdy_k3 !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready: ready at T+2=%b T+3=%b, need 0 1", rdy_k2, rdy_k3);
    end
    n_tests++;
    if (wcyc.size() != 2) begin
      n_fail++; $display("FAIL b2b_writes: got %0d writes, need 2", wcyc.size());
    end else if (wcyc[0] != 1 || wcyc[1] != 4 || wdat[0] !== 64'hA1A2A3A4A5A6A7A8 || wdat[1] !== 64'hB1B2B3B4B5B6B7B8) begin
      n_fail++; $display("FAIL b2b_writes: cyc %0d/%0d data %h/%h, need 1/4 a1a2a3a4a5a6a7a8/b1b2b3b4b5b6b7b8",
                         wcyc[0], wcyc[1], wdat[0], wdat[1]);
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    int j, n;
    logic [63:0] a, w;
    logic [1:0] s;
    for (int it = 0; it < 60; it++) begin
      j = int'($urandom_range(1, 0));
      s = 2'($urandom);
      n = 8 >> s;
      a = {$urandom, $urandom};
      if ($urandom_range(3, 0) != 0) a = a & ~64'(n - 1);
      w = {$urandom, $urandom};
      old_word[j] = {$urandom, $urandom};
      e = expect_obs(lat_of(j), a, s, w, old_word[j]);
      do_req(j, a, s, w, o);
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL random[%0d] lat=%0d addr=%h size=%0d: got %h need %h", it, lat_of(j), a, s, o, e);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rv[0] = 1'b0; rv[1] = 1'b0;
    reset = 1'b1;
    req_addr = '0; req_size = '0; req_wdata = '0;
    mrdat[0] = '0; mrdat[1] = '0;
    old_word[0] = '0; old_word[1] = '0;
    test_reset();
    test_byte_store();
    test_word_store();
    test_double_store();
    test_misaligned();
    test_reset_mid_op();
    test_lat3_half();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
